snoop_bus_arbiter: RTL and testbench

- Shared-bus controller for the MSI snooping caches.
- Takes per-cache bus requests and grants one cache at a time, round-robin.
- Latches the winner's bus message and address and broadcasts them to every snooper.
- Resolves the data source: a cache-to-cache flush, or fixed-latency memory. It then signals `data_valid` back to the requester, closing the transaction.

---
 rtl/snoop_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin shared-bus arbiter for MSI snooping caches: grant, broadcast, flush-or-memory data return.
// Optional transaction statistics counters are enabled by defining SNOOP_BUS_ARB_STATS_EN.
module snoop_bus_arbiter #(
    parameter int NUM_CPUS = 2,
    parameter int ADDR_W   = 2,
    parameter int MEM_LAT  = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CPUS-1:0]        req_i,
    input  logic [3*NUM_CPUS-1:0]      msg_i,
    input  logic [ADDR_W*NUM_CPUS-1:0] addr_i,
    input  logic [NUM_CPUS-1:0]        flush_i,
    output logic [NUM_CPUS-1:0]        gnt_o,
    output logic [2:0]                 bus_msg_o,
    output logic [ADDR_W-1:0]          bus_addr_o,
    output logic [NUM_CPUS-1:0]        bus_src_o,
    output logic [NUM_CPUS-1:0]        data_valid_o,
    output logic                       busy_o
`ifdef SNOOP_BUS_ARB_STATS_EN
    ,
    output logic [15:0]                txn_cnt_o,
    output logic [15:0]                flush_cnt_o,
    output logic [15:0]                mem_cnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_CPUS);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [2:0] MSG_UPGR = 3'd3;

    typedef enum logic [2:0] {IDLE, GRANT, SNOOP, MEM, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CPUS-1:0] gnt_d, src_d, dv_d;
    logic [2:0]         msg_d;
    logic [ADDR_W-1:0]  addr_d;
    logic               busy_d;
    logic               to_done;

    logic [2:0]         msg_a  [NUM_CPUS];
    logic [ADDR_W-1:0]  addr_a [NUM_CPUS];
    logic [IDX_W-1:0]   winner, cand;
    logic               found;
    logic [NUM_CPUS-1:0] owner_oh, flush_m;

    for (genvar k = 0; k < NUM_CPUS; k++) begin : g_unpack
        assign msg_a[k]  = msg_i[3*k +: 3];
        assign addr_a[k] = addr_i[ADDR_W*k +: ADDR_W];
    end

    function automatic logic [NUM_CPUS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CPUS-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Search upward from ptr+1 so the most recently served cache is considered last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_CPUS; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_CPUS);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_oh = onehot(owner_q);
    assign flush_m  = flush_i & ~owner_oh;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        msg_d   = bus_msg_o;
        addr_d  = bus_addr_o;
        src_d   = bus_src_o;
        dv_d    = '0;
        to_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    owner_d = winner;
                    gnt_d   = onehot(winner);
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (msg_a[owner_q] == 3'd0 || msg_a[owner_q] > MSG_UPGR) begin
                    state_d = IDLE;
                end else begin
                    msg_d   = msg_a[owner_q];
                    addr_d  = addr_a[owner_q];
                    src_d   = owner_oh;
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
                if (bus_msg_o == MSG_UPGR || flush_m != '0 || MEM_LAT == 1) begin
                    to_done = 1'b1;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = MEM;
                end
            end
            MEM: begin
                // Leaving on the decrement to zero keeps DONE at cycle 2+MEM_LAT.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    to_done = 1'b1;
                end
            end
            DONE: begin
                ptr_d   = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (to_done) begin
            state_d = DONE;
            dv_d    = owner_oh;
            msg_d   = '0;
            src_d   = '0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= IDX_W'(NUM_CPUS - 1);
            cnt_q        <= '0;
            gnt_o        <= '0;
            bus_msg_o    <= '0;
            bus_addr_o   <= '0;
            bus_src_o    <= '0;
            data_valid_o <= '0;
            busy_o       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            gnt_o        <= gnt_d;
            bus_msg_o    <= msg_d;
            bus_addr_o   <= addr_d;
            bus_src_o    <= src_d;
            data_valid_o <= dv_d;
            busy_o       <= busy_d;
        end
    end

`ifdef SNOOP_BUS_ARB_STATS_EN
    logic kind_flush_q, kind_mem_q;

    // Resolution is captured in SNOOP and counted once the transaction reaches DONE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            kind_flush_q <= 1'b0;
            kind_mem_q   <= 1'b0;
            txn_cnt_o    <= '0;
            flush_cnt_o  <= '0;
            mem_cnt_o    <= '0;
        end else begin
            if (state_q == SNOOP) begin
                kind_flush_q <= (bus_msg_o != MSG_UPGR) && (flush_m != '0);
                kind_mem_q   <= (bus_msg_o != MSG_UPGR) && (flush_m == '0);
            end
            if (state_q == DONE) begin
                if (txn_cnt_o != '1) txn_cnt_o <= txn_cnt_o + 16'd1;
                if (kind_flush_q && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 16'd1;
                if (kind_mem_q && mem_cnt_o != '1) mem_cnt_o <= mem_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed vector table, corner sequences, randomized model run.
module tb_snoop_bus_arbiter;
    localparam int NC = 2;
    localparam int AW = 2;
    localparam int ML = 3;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic [NC-1:0]     req_i = '0;
    logic [3*NC-1:0]   msg_i = '0;
    logic [AW*NC-1:0]  addr_i = '0;
    logic [NC-1:0]     flush_i = '0;
    logic [NC-1:0]     gnt_o, bus_src_o, data_valid_o;
    logic [2:0]        bus_msg_o;
    logic [AW-1:0]     bus_addr_o;
    logic              busy_o;
`ifdef SNOOP_BUS_ARB_STATS_EN
    logic [15:0]       txn_cnt_o, flush_cnt_o, mem_cnt_o;
`endif

    snoop_bus_arbiter #(.NUM_CPUS(NC), .ADDR_W(AW), .MEM_LAT(ML)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .msg_i(msg_i), .addr_i(addr_i),
        .flush_i(flush_i), .gnt_o(gnt_o), .bus_msg_o(bus_msg_o), .bus_addr_o(bus_addr_o),
        .bus_src_o(bus_src_o), .data_valid_o(data_valid_o), .busy_o(busy_o)
`ifdef SNOOP_BUS_ARB_STATS_EN
        , .txn_cnt_o(txn_cnt_o), .flush_cnt_o(flush_cnt_o), .mem_cnt_o(mem_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [NC-1:0] oh(input int i);
        return NC'(1) << i;
    endfunction

    typedef struct {
        logic [NC-1:0]    req;
        logic [3*NC-1:0]  msg;
        logic [AW*NC-1:0] addr;
        logic [NC-1:0]    flush;
        logic [NC-1:0]    gnt;
        logic [2:0]       bmsg;
        logic [AW-1:0]    baddr;
        int               lat;   // cycles from request edge to data_valid; 0 = no transaction
    } vec_t;

    typedef struct packed {
        logic [NC-1:0] gnt;
        logic [2:0]    msg;
        logic [AW-1:0] addr;
        logic [NC-1:0] src;
        logic [NC-1:0] dv;
        logic          busy;
        logic          snoop;
        logic [NC-1:0] flush;
    } frame_t;

    vec_t tbl [9];

    task automatic do_reset();
        req_i = '0; msg_i = '0; addr_i = '0; flush_i = '0;
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("reset gnt",  32'(gnt_o), 32'd0);
        chk("reset msg",  32'(bus_msg_o), 32'd0);
        chk("reset addr", 32'(bus_addr_o), 32'd0);
        chk("reset src",  32'(bus_src_o), 32'd0);
        chk("reset dv",   32'(data_valid_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int last;
        @(posedge clk); #1;
        req_i = v.req; msg_i = v.msg; addr_i = v.addr; flush_i = v.flush;
        last = (v.lat == 0) ? 2 : v.lat + 1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            if (c == 2) req_i = '0;
            @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d gnt", idx), 32'(gnt_o), 32'(v.gnt));
                chk($sformatf("v%0d busy", idx), 32'(busy_o), 32'd1);
            end else if (v.lat == 0) begin
                chk($sformatf("v%0d nobcast", idx), 32'(bus_msg_o), 32'd0);
                chk($sformatf("v%0d idle", idx), 32'(busy_o), 32'd0);
                chk($sformatf("v%0d nodv", idx), 32'(data_valid_o), 32'd0);
            end else if (c == 2) begin
                chk($sformatf("v%0d msg", idx), 32'(bus_msg_o), 32'(v.bmsg));
                chk($sformatf("v%0d addr", idx), 32'(bus_addr_o), 32'(v.baddr));
                chk($sformatf("v%0d src", idx), 32'(bus_src_o), 32'(v.gnt));
            end else if (c == v.lat) begin
                chk($sformatf("v%0d dv", idx), 32'(data_valid_o), 32'(v.gnt));
                chk($sformatf("v%0d done msg", idx), 32'(bus_msg_o), 32'd0);
            end else if (c == v.lat + 1) begin
                chk($sformatf("v%0d end busy", idx), 32'(busy_o), 32'd0);
                chk($sformatf("v%0d end dv", idx), 32'(data_valid_o), 32'd0);
            end else begin
                chk($sformatf("v%0d mem msg c%0d", idx, c), 32'(bus_msg_o), 32'(v.bmsg));
                chk($sformatf("v%0d early dv c%0d", idx, c), 32'(data_valid_o), 32'd0);
            end
        end
        msg_i = '0; addr_i = '0; flush_i = '0;
    endtask

    // Transaction-level reference: each arbitration expands into a list of expected cycles.
    frame_t        q[$];
    logic [NC-1:0] rq, gprev;
    logic [2:0]    cm [NC];
    logic [AW-1:0] ca [NC];
    int            lastw;

    function automatic logic [2:0] pick_msg();
        int v;
        v = $urandom_range(0, 9);
        if (v < 8) return 3'(v % 3 + 1);
        if (v == 8) return 3'd0;
        return 3'($urandom_range(4, 7));
    endfunction

    task automatic schedule();
        int w, n;
        logic [2:0] m;
        logic [NC-1:0] fl;
        frame_t f;
        w = -1;
        for (int i = 1; i <= NC; i++) begin
            int c;
            c = (lastw + i) % NC;
            if (w < 0 && rq[c]) w = c;
        end
        f = '0; f.gnt = oh(w); f.busy = 1'b1;
        q.push_back(f);
        m = cm[w];
        if (m == 3'd0 || m > 3'd3) return;
        fl = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
        n = (m == 3'd3 || (fl & ~oh(w)) != '0) ? 1 : ML;
        for (int j = 0; j < n; j++) begin
            f = '0; f.msg = m; f.addr = ca[w]; f.src = oh(w); f.busy = 1'b1;
            f.snoop = (j == 0); f.flush = fl;
            q.push_back(f);
        end
        f = '0; f.dv = oh(w); f.busy = 1'b1;
        q.push_back(f);
        lastw = w;
    endtask

    task automatic rnd_run(input int ncyc);
        frame_t f;
        q.delete(); rq = '0; gprev = '0; lastw = NC - 1;
        for (int k = 0; k < NC; k++) begin cm[k] = '0; ca[k] = '0; end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            f = (q.size() > 0) ? q.pop_front() : frame_t'('0);
            for (int k = 0; k < NC; k++) begin
                if (gprev[k]) rq[k] = 1'b0;
                if (!rq[k] && $urandom_range(0, 3) == 0) begin
                    rq[k] = 1'b1; cm[k] = pick_msg(); ca[k] = AW'($urandom);
                end
                msg_i[3*k +: 3]   = rq[k] ? cm[k] : 3'($urandom);
                addr_i[AW*k +: AW] = rq[k] ? ca[k] : AW'($urandom);
            end
            gprev = f.gnt;
            req_i = rq;
            flush_i = f.snoop ? f.flush : NC'($urandom);
            if (!f.busy && rq != '0) schedule();
            @(negedge clk);
            chk($sformatf("rnd%0d gnt", cyc), 32'(gnt_o), 32'(f.gnt));
            chk($sformatf("rnd%0d busy", cyc), 32'(busy_o), 32'(f.busy));
            chk($sformatf("rnd%0d dv", cyc), 32'(data_valid_o), 32'(f.dv));
            chk($sformatf("rnd%0d msg", cyc), 32'(bus_msg_o), 32'(f.msg));
            chk($sformatf("rnd%0d src", cyc), 32'(bus_src_o), 32'(f.src));
            if (f.msg != 3'd0) chk($sformatf("rnd%0d addr", cyc), 32'(bus_addr_o), 32'(f.addr));
        end
    endtask

    initial begin
        //          req    msg {c1,c0}      addr {c1,c0}   flush  gnt    bmsg  baddr lat
        tbl[0] = '{2'b01, {3'd0, 3'd1}, {2'd0, 2'd2}, 2'b00, 2'b01, 3'd1, 2'd2, 5};
        tbl[1] = '{2'b11, {3'd2, 3'd1}, {2'd1, 2'd0}, 2'b01, 2'b10, 3'd2, 2'd1, 3};
        tbl[2] = '{2'b01, {3'd0, 3'd3}, {2'd0, 2'd3}, 2'b10, 2'b01, 3'd3, 2'd3, 3};
        tbl[3] = '{2'b10, {3'd1, 3'd0}, {2'd0, 2'd0}, 2'b10, 2'b10, 3'd1, 2'd0, 5};
        tbl[4] = '{2'b11, {3'd1, 3'd2}, {2'd2, 2'd1}, 2'b11, 2'b01, 3'd2, 2'd1, 3};
        tbl[5] = '{2'b10, {3'd0, 3'd0}, {2'd0, 2'd0}, 2'b00, 2'b10, 3'd0, 2'd0, 0};
        tbl[6] = '{2'b11, {3'd2, 3'd1}, {2'd3, 2'd1}, 2'b00, 2'b10, 3'd2, 2'd3, 5};
        tbl[7] = '{2'b11, {3'd1, 3'd6}, {2'd0, 2'd0}, 2'b00, 2'b01, 3'd0, 2'd0, 0};
        tbl[8] = '{2'b11, {3'd1, 3'd1}, {2'd0, 2'd2}, 2'b00, 2'b01, 3'd1, 2'd2, 5};

        do_reset();
        for (int i = 0; i < 9; i++) run_vec(tbl[i], i);
`ifdef SNOOP_BUS_ARB_STATS_EN
        chk("stats txn",   32'(txn_cnt_o),   32'd7);
        chk("stats flush", 32'(flush_cnt_o), 32'd2);
        chk("stats mem",   32'(mem_cnt_o),   32'd4);
`endif

        // Both caches requesting continuously: grants must alternate starting with CPU0.
        do_reset();
        @(posedge clk); #1;
        req_i = 2'b11; msg_i = {3'd1, 3'd1}; addr_i = {2'd1, 2'd2};
        for (int g = 0; g < 3; g++) begin
            int k;
            logic [NC-1:0] expg;
            expg = (g % 2 == 0) ? 2'b01 : 2'b10;
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                if (gnt_o != '0) break;
                k++;
            end
            if (k >= 20) chk($sformatf("alt%0d timeout", g), 32'd0, 32'd1);
            else chk($sformatf("alt%0d gnt", g), 32'(gnt_o), 32'(expg));
        end

        // Reset during MEM clears outputs at once and restores the pointer.
        do_reset();
        run_vec(tbl[0], 90);
        @(posedge clk); #1;
        req_i = 2'b10; msg_i = {3'd1, 3'd0}; addr_i = {2'd1, 2'd0};
        repeat (3) @(posedge clk);
        #1 req_i = '0;
        #2;
        chk("mem busy", 32'(busy_o), 32'd1);
        chk("mem msg", 32'(bus_msg_o), 32'd1);
        rst_i = 1'b0;
        #1;
        chk("arst gnt",  32'(gnt_o), 32'd0);
        chk("arst msg",  32'(bus_msg_o), 32'd0);
        chk("arst addr", 32'(bus_addr_o), 32'd0);
        chk("arst src",  32'(bus_src_o), 32'd0);
        chk("arst dv",   32'(data_valid_o), 32'd0);
        chk("arst busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b1;
        req_i = 2'b11; msg_i = {3'd1, 3'd1};
        @(posedge clk);
        @(negedge clk);
        chk("arst restart gnt", 32'(gnt_o), 32'b01);

        do_reset();
        rnd_run(3000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
